cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Parametrised coprocessor-0 for the 5-stage MIPS32 pipeline. Holds SR, Cause, EPC, PRId, Count and Compare. Arbitrates synchronous exceptions, hardware interrupts, an internal Count/Compare timer interrupt and `eret`. Drives the PC redirect into IF. It sits beside the MEM stage, where exceptions are committed.

## Interface
Parameters:
- `NUM_HWINT`, 6: external interrupt lines, range 1..6, mapped to Cause.IP and SR.IM bits [10 +: NUM_HWINT].
- `PRID_VAL`, 32'h0000_0000: constant read from PRId.
- `TIMER_EN`, 1: when 1, the timer interrupt is ORed into line NUM_HWINT-1.
- `EXC_VECTOR`, 32'h0000_4180: handler entry address.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `hwint`, in, NUM_HWINT: level interrupt requests, already synchronous.
- `rd_addr`, in, 5: mfc0 register number.
- `rd_data`, out, 32: mfc0 read data, combinational.
- `we`, in, 1: mtc0 write enable.
- `wr_addr`, in, 5: mtc0 register number.
- `wr_data`, in, 32: mtc0 data.
- `exc_req`, in, 1: synchronous exception at MEM.
- `exc_code`, in, 5: ExcCode for `exc_req`.
- `exc_pc`, in, 32: PC of the instruction in MEM.
- `exc_bd`, in, 1: the instruction in MEM is in a branch delay slot.
- `eret`, in, 1: eret at MEM.
- `int_req`, out, 1: interrupt pending and enabled.
- `flush`, out, 1: pipeline flush and redirect this cycle.
- `redirect_pc`, out, 32: target PC when `flush`=1.
- `epc`, out, 32: EPC register.

## Operation
Register map:
- 12 SR: IM [10 +: NUM_HWINT], EXL [1], IE [0]. All other bits read 0.
- 13 Cause: BD [31], TI [30], IP [10 +: NUM_HWINT], ExcCode [6:2].
- 14 EPC.
- 15 PRId.
- 9 Count.
- 11 Compare.
- Any other address reads 0.

Reset values:
- SR = IM all 1, EXL=0, IE=1.
- Cause, EPC, Count, Compare = 0.
- Outputs `flush`=0, `int_req`=0.

Per-cycle behaviour:
- Cause.IP ← `hwint`, with TI ORed into bit NUM_HWINT-1 when TIMER_EN=1. IP is not software-writable.
- Count increments by 1 every cycle and wraps from 2^32-1 to 0.
- TI is set on the cycle Count == Compare. TI is cleared by any mtc0 to Compare.
- `int_req` = |(IP & IM) & IE & ~EXL.

Events are resolved in one cycle, in priority order. Only the highest-priority event acts.
1. Entry, when `exc_req` or `int_req`:
   - ExcCode ← `exc_code` for an exception, or 0 for an interrupt. An exception beats a simultaneous interrupt.
   - If EXL=0: EPC ← `exc_bd` ? `exc_pc`-4 : `exc_pc`, and BD ← `exc_bd`. If EXL=1, EPC and BD hold.
   - EXL ← 1. `flush`=1, `redirect_pc`=EXC_VECTOR.
2. `eret`: EXL ← 0. `flush`=1, `redirect_pc`=EPC.
3. `we`:
   - SR writes IM and the low 2 bits only.
   - Cause writes nothing; it is read-only here.
   - EPC writes the full word.
   - Count and Compare write the full word.
   - Writes to other addresses are ignored.
   - The write is dropped in any cycle where 1 or 2 fires.

`rd_data` reflects register state before this cycle's update. There is no write-to-read bypass; the pipeline forwards.

## Timing
- `hwint` → Cause.IP: 1 cycle. `hwint` → `int_req`: 1 cycle.
- `flush` and `redirect_pc` are combinational from inputs plus state, in the same cycle as the event.
- Count==Compare → TI: next edge. TI → `int_req`: a further cycle, via IP.
- Reset mid-operation clears all state immediately. A pending entry is lost.
- Simultaneous `exc_req` and `eret`: the entry wins, and EXL stays 1.

## Structure
- A shared package `cp0_pkg` holds the register numbers (SR, CAUSE, EPC, PRID, COUNT, COMPARE), the bit positions for IE, EXL, BD, TI and the IP/IM base, and the ExcCode constant INT=0.
- One natural sub-module, `cp0_timer`, holds Count, Compare, compare detection and TI. It takes the write port and a TI-clear input.

## Test plan
- Reset: release `reset` → SR reads 32'h0000_FC01 (NUM_HWINT=6), Cause, EPC and Count read 0, `int_req`=0.
- Interrupt entry: `hwint`=6'b000100, `exc_pc`=32'h3010 → `int_req` rises 1 cycle later. On that cycle `flush`=1, `redirect_pc`=32'h4180, EPC=32'h3010, ExcCode=0, EXL=1.
- Delay-slot exception: `exc_req`=1, `exc_code`=12, `exc_bd`=1, `exc_pc`=32'h3024 → EPC=32'h3020, BD=1, ExcCode=12. A second `exc_req` while EXL=1 leaves EPC at 32'h3020.
- eret: after an entry, `eret`=1 → `flush`=1, `redirect_pc`=EPC, EXL=0. A concurrent `we` to EPC is dropped.
- Timer: write Compare=5, then Count=0 → TI=1 after Count reaches 5, `int_req` the cycle after. Writing Compare clears TI.
- Masking: IM=0, `hwint` all 1s → `int_req`=0 and Cause.IP reads 6'h3F. A simultaneous `exc_req` and interrupt yields ExcCode=`exc_code`.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field bit positions and ExcCode constants.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned TI_BIT  = 30;
  localparam int unsigned IP_BASE = 10;

  localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match detection and the sticky TI flag.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        ti_clr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, compare_q;
  logic        ti_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      if (we && wr_addr == REG_COUNT) count_q <= wr_data;
      else                            count_q <= count_q + 32'd1;
      if (we && wr_addr == REG_COMPARE) compare_q <= wr_data;
      // A Compare write on a matching cycle clears TI rather than setting it.
      if (ti_clr)                      ti_q <= 1'b0;
      else if (count_q == compare_q)   ti_q <= 1'b1;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 for the MEM stage: status/cause/EPC state, exception and interrupt entry,
// eret and the PC redirect into IF.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter bit          TIMER_EN   = 1'b1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 we,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic                 eret,
  output logic                 int_req,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          epc
);

  logic [NUM_HWINT-1:0] im_q, ip_q, ip_d;
  logic                 exl_q, ie_q, bd_q;
  logic [4:0]           exccode_q;
  logic [31:0]          epc_q;
  logic [31:0]          count, compare;
  logic                 ti, entry, wr_ok;

  always_comb begin
    ip_d = hwint;
    if (TIMER_EN) ip_d[NUM_HWINT-1] = hwint[NUM_HWINT-1] | ti;
  end

  always_comb begin
    int_req     = (|(ip_q & im_q)) & ie_q & ~exl_q;
    entry       = exc_req | int_req;
    flush       = entry | eret;
    // mtc0 only lands in a cycle with no entry and no eret.
    wr_ok       = we & ~entry & ~eret;
    redirect_pc = '0;
    if (entry)     redirect_pc = EXC_VECTOR;
    else if (eret) redirect_pc = epc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q      <= '1;
      exl_q     <= 1'b0;
      ie_q      <= 1'b1;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      ip_q      <= '0;
      epc_q     <= '0;
    end else begin
      ip_q <= ip_d;
      if (entry) begin
        exccode_q <= exc_req ? exc_code : EXC_INT;
        if (!exl_q) begin
          epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          bd_q  <= exc_bd;
        end
        exl_q <= 1'b1;
      end else if (eret) begin
        exl_q <= 1'b0;
      end else if (wr_ok) begin
        case (wr_addr)
          REG_SR: begin
            im_q  <= wr_data[IP_BASE +: NUM_HWINT];
            exl_q <= wr_data[EXL_BIT];
            ie_q  <= wr_data[IE_BIT];
          end
          REG_EPC: epc_q <= wr_data;
          default: ;
        endcase
      end
    end
  end

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ti_clr  (wr_ok && wr_addr == REG_COMPARE),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_SR: begin
        rd_data[IP_BASE +: NUM_HWINT] = im_q;
        rd_data[EXL_BIT]              = exl_q;
        rd_data[IE_BIT]               = ie_q;
      end
      REG_CAUSE: begin
        rd_data[BD_BIT]               = bd_q;
        rd_data[TI_BIT]               = ti;
        rd_data[IP_BASE +: NUM_HWINT] = ip_q;
        rd_data[6:2]                  = exccode_q;
      end
      REG_EPC:     rd_data = epc_q;
      REG_PRID:    rd_data = PRID_VAL;
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
      default:     rd_data = '0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: reset, interrupt/exception entry, eret, timer, masking.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  hwint = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic        eret = 1'b0;
  logic        int_req, flush;
  logic [31:0] redirect_pc, epc;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_exception_unit dut (
    .clk         (clk),
    .reset       (reset),
    .hwint       (hwint),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .exc_req     (exc_req),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .eret        (eret),
    .int_req     (int_req),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Park Compare far away so the reset-time Count==Compare match never raises TI.
    we = 1'b1; wr_addr = 5'd11; wr_data = 32'hFFFF_0000;
    rd(5'd12, d);
    n_tests++; if (d !== 32'h0000_FC01) begin n_fail++; $display("FAIL reset_sr got %h want %h", d, 32'h0000_FC01); end
    rd(5'd13, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h want 0", d); end
    rd(5'd9, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", d); end
    n_tests++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", epc); end
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req got %b want 0", int_req); end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic clear_exl;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_irq;
    logic [31:0] d;
    @(negedge clk);
    hwint = 6'b000100; exc_pc = 32'h3010;
    #1;
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", int_req); end
    @(negedge clk);
    #1;
    n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL irq_int_req got %b want 1", int_req); end
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h4180) begin
      n_fail++; $display("FAIL irq_flush got %b/%h want 1/00004180", flush, redirect_pc); end
    @(negedge clk);
    hwint = '0;
    n_tests++; if (epc !== 32'h3010) begin n_fail++; $display("FAIL irq_epc got %h want 00003010", epc); end
    rd(5'd13, d);
    n_tests++; if (d[6:2] !== 5'd0) begin n_fail++; $display("FAIL irq_exccode got %0d want 0", d[6:2]); end
    rd(5'd12, d);
    n_tests++; if (d[1] !== 1'b1) begin n_fail++; $display("FAIL irq_exl got %b want 1", d[1]); end
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL irq_masked_by_exl got %b want 0", int_req); end
    clear_exl();
  endtask

  task automatic test_exc_bd;
    logic [31:0] d;
    @(negedge clk);
    exc_req = 1'b1; exc_code = 5'd12; exc_bd = 1'b1; exc_pc = 32'h3024;
    #1;
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h4180) begin
      n_fail++; $display("FAIL exc_flush got %b/%h want 1/00004180", flush, redirect_pc); end
    @(negedge clk);
    exc_req = 1'b0;
    n_tests++; if (epc !== 32'h3020) begin n_fail++; $display("FAIL exc_bd_epc got %h want 00003020", epc); end
    rd(5'd13, d);
    n_tests++; if (d[31] !== 1'b1 || d[6:2] !== 5'd12) begin
      n_fail++; $display("FAIL exc_bd_cause got bd=%b code=%0d want bd=1 code=12", d[31], d[6:2]); end
    @(negedge clk);
    exc_req = 1'b1; exc_code = 5'd4; exc_bd = 1'b0; exc_pc = 32'h3100;
    @(negedge clk);
    exc_req = 1'b0;
    n_tests++; if (epc !== 32'h3020) begin n_fail++; $display("FAIL nested_epc got %h want 00003020", epc); end
    rd(5'd13, d);
    n_tests++; if (d[31] !== 1'b1 || d[6:2] !== 5'd4) begin
      n_fail++; $display("FAIL nested_cause got bd=%b code=%0d want bd=1 code=4", d[31], d[6:2]); end
  endtask

  task automatic test_eret;
    logic [31:0] d;
    @(negedge clk);
    eret = 1'b1; we = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h3020) begin
      n_fail++; $display("FAIL eret_redirect got %b/%h want 1/00003020", flush, redirect_pc); end
    @(negedge clk);
    eret = 1'b0; we = 1'b0;
    n_tests++; if (epc !== 32'h3020) begin n_fail++; $display("FAIL eret_we_dropped got %h want 00003020", epc); end
    rd(5'd12, d);
    n_tests++; if (d[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl got %b want 0", d[1]); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL eret_idle_flush got %b want 0", flush); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    @(negedge clk);
    exc_req = 1'b1; eret = 1'b1; exc_code = 5'd5; exc_bd = 1'b0; exc_pc = 32'h3200;
    #1;
    n_tests++; if (redirect_pc !== 32'h4180) begin
      n_fail++; $display("FAIL exc_eret_redirect got %h want 00004180", redirect_pc); end
    @(negedge clk);
    exc_req = 1'b0; eret = 1'b0;
    rd(5'd12, d);
    n_tests++; if (d[1] !== 1'b1 || epc !== 32'h3200) begin
      n_fail++; $display("FAIL exc_eret_state got exl=%b epc=%h want exl=1 epc=00003200", d[1], epc); end
    eret = 1'b1;
    #1;
    n_tests++; if (redirect_pc !== 32'h3200) begin
      n_fail++; $display("FAIL b2b_eret_redirect got %h want 00003200", redirect_pc); end
    @(negedge clk);
    eret = 1'b0;
  endtask

  task automatic test_timer;
    logic [31:0] d;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd11; wr_data = 32'd5;
    @(negedge clk);
    wr_addr = 5'd9; wr_data = 32'd0;
    @(negedge clk);
    we = 1'b0;
    rd(5'd9, d);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL timer_count0 got %0d want 0", d); end
    repeat (5) @(negedge clk);
    rd(5'd9, d);
    n_tests++; if (d !== 32'd5) begin n_fail++; $display("FAIL timer_count5 got %0d want 5", d); end
    rd(5'd13, d);
    n_tests++; if (d[30] !== 1'b0) begin n_fail++; $display("FAIL timer_ti_early got %b want 0", d[30]); end
    @(negedge clk);
    rd(5'd13, d);
    n_tests++; if (d[30] !== 1'b1 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL timer_ti_set got ti=%b int=%b want ti=1 int=0", d[30], int_req); end
    @(negedge clk);
    #1;
    n_tests++; if (int_req !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL timer_int_req got int=%b flush=%b want 1/1", int_req, flush); end
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd11; wr_data = 32'hFFFF_0000;
    @(negedge clk);
    we = 1'b0;
    rd(5'd13, d);
    n_tests++; if (d[30] !== 1'b0) begin n_fail++; $display("FAIL timer_ti_clear got %b want 0", d[30]); end
    @(negedge clk);
    clear_exl();
  endtask

  task automatic test_mask;
    logic [31:0] d;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0001;
    @(negedge clk);
    we = 1'b0; hwint = 6'h3F;
    @(negedge clk);
    rd(5'd13, d);
    n_tests++; if (d[15:10] !== 6'h3F || int_req !== 1'b0) begin
      n_fail++; $display("FAIL mask_ip got ip=%h int=%b want ip=3f int=0", d[15:10], int_req); end
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
    @(negedge clk);
    we = 1'b0;
    exc_req = 1'b1; exc_code = 5'd10; exc_bd = 1'b0; exc_pc = 32'h3300;
    #1;
    n_tests++; if (int_req !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL mask_restore got int=%b flush=%b want 1/1", int_req, flush); end
    @(negedge clk);
    exc_req = 1'b0; hwint = '0;
    rd(5'd13, d);
    n_tests++; if (d[6:2] !== 5'd10 || epc !== 32'h3300) begin
      n_fail++; $display("FAIL exc_beats_int got code=%0d epc=%h want 10/00003300", d[6:2], epc); end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_exc_bd();
    test_eret();
    test_back_to_back();
    test_timer();
    test_mask();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
